ctrl_coef_sequencer: RTL and testbench

- Per-output-sample sequencer that drives the coefficient address counter (ctrl_ramdrv_coefcnt) directly upstream of it.
- On each accepted request it selects the polyphase coefficient bank for the requested phase and issues one load command, then exactly TAPS_PER_PHASE count commands.
- Emits MAC framing strobes (first/last tap) and a completion pulse for the datapath/top controller.

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/ctrl_tap_cnt.sv | 37 +++
 rtl/ctrl_coef_sequencer.sv | 131 +++++++++++++
 tb/tb_ctrl_coef_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared sequencer states, coefficient-counter commands and bank address helper
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // {load, cnt} command pairs understood by the coefficient address counter
    localparam logic [1:0] SLEEP        = 2'b00;
    localparam logic [1:0] LOAD_COUNTER = 2'b10;
    localparam logic [1:0] COUNTING     = 2'b01;

    function automatic int unsigned bank_base(input int unsigned phase, input int unsigned taps);
        return phase * taps;
    endfunction

endpackage

// File: rtl/ctrl_tap_cnt.sv
// rtl/ctrl_tap_cnt.sv - loadable up counter with terminal-count flag
module ctrl_tap_cnt #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LAST  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/ctrl_coef_sequencer.sv
// rtl/ctrl_coef_sequencer.sv - per-sample polyphase coefficient sweep sequencer
module ctrl_coef_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_ADDRESS_WIDTH = 12,
    parameter int unsigned NUM_PHASES         = 8,
    parameter int unsigned PHASE_WIDTH        = 3,
    parameter int unsigned TAPS_PER_PHASE     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [PHASE_WIDTH-1:0]        phase,
    input  logic                          abort,
    output logic                          ready,
    output logic                          coef_clr,
    output logic                          coef_load,
    output logic                          coef_cnt,
    output logic [DATA_ADDRESS_WIDTH-1:0] coef_ptr,
    output logic                          mac_first,
    output logic                          mac_last,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned TW = $clog2(TAPS_PER_PHASE + 1);

    if (TAPS_PER_PHASE < 1) begin : g_chk_taps
        $error("TAPS_PER_PHASE must be at least 1");
    end
    if ((2 ** PHASE_WIDTH) < NUM_PHASES) begin : g_chk_phase
        $error("PHASE_WIDTH too narrow for NUM_PHASES");
    end
    if (NUM_PHASES * TAPS_PER_PHASE > (2 ** DATA_ADDRESS_WIDTH)) begin : g_chk_span
        $error("coefficient banks exceed DATA_ADDRESS_WIDTH");
    end

    state_t                        state_q, state_d;
    logic [DATA_ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic                          err_q, err_d;
    logic                          clr_q, clr_d;
    logic [1:0]                    cmd;
    logic                          tap_load, tap_inc, tap_last;
    logic [TW-1:0]                 tap_cnt;
    logic                          phase_ok;

    assign phase_ok = (32'(phase) < NUM_PHASES);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        err_d    = 1'b0;
        clr_d    = abort;
        cmd      = SLEEP;
        tap_load = 1'b0;
        tap_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (phase_ok) begin
                        ptr_d   = DATA_ADDRESS_WIDTH'(bank_base(32'(phase), TAPS_PER_PHASE));
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                cmd      = LOAD_COUNTER;
                tap_load = 1'b1;
                state_d  = COUNT;
            end
            COUNT: begin
                cmd     = COUNTING;
                tap_inc = 1'b1;
                if (tap_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort overrides whatever the state wanted next; current-cycle commands stand
        if (abort) begin
            state_d  = IDLE;
            tap_load = 1'b1;
            tap_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
        end
    end

    ctrl_tap_cnt #(
        .WIDTH (TW),
        .LAST  (TAPS_PER_PHASE - 1)
    ) u_tap_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tap_load),
        .load_val_i ('0),
        .inc_i      (tap_inc),
        .cnt_o      (tap_cnt),
        .tc_o       (tap_last)
    );

    assign ready                = (state_q == IDLE);
    assign {coef_load, coef_cnt} = cmd;
    assign coef_ptr             = ptr_q;
    assign coef_clr             = clr_q;
    assign err                  = err_q;
    assign done                 = (state_q == DONE);
    assign mac_first            = (state_q == COUNT) && (tap_cnt == '0);
    assign mac_last             = (state_q == COUNT) && tap_last;

endmodule

// File: tb/tb_ctrl_coef_sequencer.sv
// tb/tb_ctrl_coef_sequencer.sv - self-checking bench for ctrl_coef_sequencer (4-tap and 1-tap builds)
module tb_ctrl_coef_sequencer;

    localparam int AW = 12;
    localparam int NP = 8;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [PW-1:0] phase = '0;

    logic          rdy[2], clr[2], ld[2], cn[2], mf[2], ml[2], dn[2], er[2];
    logic [AW-1:0] ptr[2];

    always #5 clk = ~clk;

    ctrl_coef_sequencer #(
        .DATA_ADDRESS_WIDTH(AW), .NUM_PHASES(NP), .PHASE_WIDTH(PW), .TAPS_PER_PHASE(4)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .phase(phase), .abort(abort),
        .ready(rdy[0]), .coef_clr(clr[0]), .coef_load(ld[0]), .coef_cnt(cn[0]),
        .coef_ptr(ptr[0]), .mac_first(mf[0]), .mac_last(ml[0]), .done(dn[0]), .err(er[0])
    );

    ctrl_coef_sequencer #(
        .DATA_ADDRESS_WIDTH(AW), .NUM_PHASES(NP), .PHASE_WIDTH(PW), .TAPS_PER_PHASE(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .phase(phase), .abort(abort),
        .ready(rdy[1]), .coef_clr(clr[1]), .coef_load(ld[1]), .coef_cnt(cn[1]),
        .coef_ptr(ptr[1]), .mac_first(mf[1]), .mac_last(ml[1]), .done(dn[1]), .err(er[1])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // downstream coefficient address counter fed by each DUT's commands
    int unsigned addr[2];
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n)     addr[d] <= 0;
            else if (clr[d]) addr[d] <= 0;
            else if (ld[d])  addr[d] <= ptr[d];
            else if (cn[d])  addr[d] <= addr[d] + 1;
        end
    end

    // reference: position within the sweep (1=load, 2..T+1 taps, T+2=done)
    bit          m_busy[2];
    int          m_pos[2];
    int unsigned m_ptr[2];
    bit          m_clr[2], m_err[2];
    int          cyc = 0;
    int          done_cyc[$];

    function automatic int taps(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_pos[d] = 0; m_ptr[d] = 0; m_clr[d] = 0; m_err[d] = 0;
        end
    endtask

    task automatic model_edge(input int d, input bit s, input int ph, input bit ab);
        int t = taps(d);
        m_clr[d] = ab;
        m_err[d] = 0;
        if (ab) begin
            m_busy[d] = 0;
        end else if (m_busy[d]) begin
            m_pos[d]++;
            if (m_pos[d] > t + 2) m_busy[d] = 0;
        end else if (s) begin
            if (ph < NP) begin
                m_busy[d] = 1; m_pos[d] = 1; m_ptr[d] = ph * t;
            end else begin
                m_err[d] = 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_flags(input int d);
        int t = taps(d);
        int k = m_pos[d] - 2;
        bit b = m_busy[d];
        bit c = b && (m_pos[d] >= 2) && (m_pos[d] <= t + 1);
        return {!b, m_clr[d], b && (m_pos[d] == 1), c, c && (k == 0), c && (k == t - 1),
                b && (m_pos[d] == t + 2), m_err[d]};
    endfunction

    task automatic check_now();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("flags%0d", d),
                  {24'b0, rdy[d], clr[d], ld[d], cn[d], mf[d], ml[d], dn[d], er[d]},
                  {24'b0, exp_flags(d)});
            check($sformatf("ptr%0d", d), {20'b0, ptr[d]}, m_ptr[d]);
            check($sformatf("excl%0d", d), {31'b0, ld[d] & cn[d]}, 32'd0);
            if (cn[d] === 1'b1)
                check($sformatf("addr%0d", d), addr[d], m_ptr[d] + m_pos[d] - 2);
        end
        if (dn[0] === 1'b1) done_cyc.push_back(cyc);
    endtask

    task automatic drive(input bit s, input int ph, input bit ab);
        start = s; phase = PW'(ph); abort = ab;
        for (int d = 0; d < 2; d++) model_edge(d, s, ph, ab);
    endtask

    task automatic step(input bit s, input int ph, input bit ab);
        @(negedge clk);
        cyc++;
        check_now();
        drive(s, ph, ab);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_now();
        rst_n = 1'b1;

        // phase 3 sweep: load, 4 taps at 12..15, done, ready
        drive(1, 3, 0);
        step(0, 0, 0);
        check("t1_ptr12", {20'b0, ptr[0]}, 32'd12);
        check("t1_load", {31'b0, ld[0]}, 32'd1);
        repeat (5) step(0, 0, 0);

        // back-to-back phase 7 then phase 0, starts while busy ignored
        done_cyc.delete();
        step(1, 7, 0);
        step(1, 5, 0);
        check("b2b_ptr28", {20'b0, ptr[0]}, 32'd28);
        repeat (5) step(1, 5, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        check("b2b_ptr0", {20'b0, ptr[0]}, 32'd0);
        repeat (5) step(0, 0, 0);
        check("b2b_ndone", done_cyc.size(), 32'd2);
        if (done_cyc.size() == 2)
            check("b2b_gap", done_cyc[1] - done_cyc[0], 32'd7);

        // out-of-range phase
        step(1, 8, 0);
        step(0, 0, 0);
        check("err8", {31'b0, er[0]}, 32'd1);
        check("err8_rdy", {31'b0, rdy[0]}, 32'd1);

        // abort in second tap cycle, then phase 1
        step(1, 2, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 1, 0);
        check("abort_clr", {31'b0, clr[0]}, 32'd1);
        repeat (2) step(0, 0, 0);
        check("abort_ptr4", {20'b0, ptr[0]}, 32'd4);
        repeat (6) step(0, 0, 0);

        // asynchronous reset between edges during a tap cycle
        step(1, 6, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("pre_rst_cnt", {31'b0, cn[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_now();
        check("rst_cnt0", {31'b0, cn[0]}, 32'd0);
        @(negedge clk);
        check_now();
        rst_n = 1'b1;
        drive(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 1) == 1), $urandom_range(0, 9), ($urandom_range(0, 15) == 0));
        end
        repeat (8) step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
